// File: rtl/nemu_pkg.sv
// nemu_pkg: shared types and helpers for the NEMU run-phase sequencer.
//   nemu_phase_t : run phase encoding (IDLE, WARMUP, MEASURE, DRAIN, DONE)
//   NEMU_TS_W    : width of timestamps and packet counters
//   nemu_sat_add : unsigned add that clamps at all-ones instead of wrapping
package nemu_pkg;

  localparam int unsigned NEMU_TS_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    MEASURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } nemu_phase_t;

  function automatic logic [NEMU_TS_W-1:0] nemu_sat_add(
    input logic [NEMU_TS_W-1:0] a,
    input logic [NEMU_TS_W-1:0] b
  );
    logic [NEMU_TS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[NEMU_TS_W] ? {NEMU_TS_W{1'b1}} : sum[NEMU_TS_W-1:0];
  endfunction

endpackage

// File: rtl/nemu_traffic_controller_if.sv
// nemu_traffic_controller_if: bundle between the sequencer and the
// network / packet sources.
//   i_start      : run start request
//   i_tx_valid/ts: packets accepted by the network, with their timestamps
//   i_rx_valid/ts: packets delivered by the network, with their timestamps
//   i_src_empty  : packet-source FIFO empty flags
//   o_*          : timestamp, source enables, phase, counters, done/timeout
// Modports: slave = sequencer side, master = network/testbench side.
interface nemu_traffic_controller_if #(
  parameter int PORTS = 4
);
  import nemu_pkg::*;

  logic                                i_start;
  logic [PORTS-1:0]                    i_tx_valid;
  logic [PORTS-1:0][NEMU_TS_W-1:0]     i_tx_ts;
  logic [PORTS-1:0]                    i_rx_valid;
  logic [PORTS-1:0][NEMU_TS_W-1:0]     i_rx_ts;
  logic [PORTS-1:0]                    i_src_empty;
  logic [NEMU_TS_W-1:0]                o_timestamp;
  logic [PORTS-1:0]                    o_src_enable;
  nemu_phase_t                         o_state;
  logic [NEMU_TS_W-1:0]                o_injected;
  logic [NEMU_TS_W-1:0]                o_delivered;
  logic                                o_done;
  logic                                o_timeout;

  modport slave (
    input  i_start, i_tx_valid, i_tx_ts, i_rx_valid, i_rx_ts, i_src_empty,
    output o_timestamp, o_src_enable, o_state, o_injected, o_delivered,
           o_done, o_timeout
  );

  modport master (
    output i_start, i_tx_valid, i_tx_ts, i_rx_valid, i_rx_ts, i_src_empty,
    input  o_timestamp, o_src_enable, o_state, o_injected, o_delivered,
           o_done, o_timeout
  );

endinterface

// File: rtl/nemu_popcount.sv
// nemu_popcount: combinational count of set bits.
//   i_bits  : WIDTH-bit input vector
//   o_count : number of ones in i_bits
module nemu_popcount #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]            i_bits,
  output logic [$clog2(WIDTH+1)-1:0]  o_count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Sum the input bits one at a time.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/nemu_traffic_controller.sv
// nemu_traffic_controller: run-phase sequencer for the NEMU traffic
// generators. Owns the global timestamp, gates the packet sources through
// WARMUP / MEASURE / DRAIN / DONE and counts measurement-window packets.
//   i_clk   : clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of nemu_traffic_controller_if (start, tx/rx events,
//             source-empty flags in; timestamp, enables, phase, counters,
//             done and timeout out; all outputs registered)
module nemu_traffic_controller
  import nemu_pkg::*;
#(
  parameter int          PORTS          = 4,
  parameter int unsigned WARMUP_CYCLES  = 600,
  parameter int unsigned MEASURE_CYCLES = 10000,
  parameter int unsigned DRAIN_TIMEOUT  = 20000
) (
  input  logic                     i_clk,
  input  logic                     reset_n,
  nemu_traffic_controller_if.slave bus
);

  localparam int CW = $clog2(PORTS + 1);
  localparam logic [NEMU_TS_W-1:0] WARMUP_LAST  = WARMUP_CYCLES - 32'd1;
  localparam logic [NEMU_TS_W-1:0] MEASURE_LAST = MEASURE_CYCLES - 32'd1;
  localparam logic [NEMU_TS_W-1:0] DRAIN_LAST   = DRAIN_TIMEOUT - 32'd1;
  localparam logic [NEMU_TS_W-1:0] WINDOW_LEN   = MEASURE_CYCLES;

  nemu_phase_t          r_state;
  nemu_phase_t          w_next_state;
  logic [NEMU_TS_W-1:0] r_phase_cnt;
  logic [NEMU_TS_W-1:0] r_timestamp;
  logic [NEMU_TS_W-1:0] r_win_start;
  logic [NEMU_TS_W-1:0] r_injected;
  logic [NEMU_TS_W-1:0] r_delivered;
  logic [CW-1:0]        r_tx_cnt;
  logic [CW-1:0]        r_rx_cnt;
  logic [CW-1:0]        w_tx_cnt;
  logic [CW-1:0]        w_rx_cnt;
  logic [PORTS-1:0]     w_tx_hit;
  logic [PORTS-1:0]     w_rx_hit;
  logic [PORTS-1:0]     r_src_enable;
  logic [PORTS-1:0]     w_src_enable_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 r_timeout;
  logic                 w_start_ok;
  logic                 w_counting;
  logic                 w_complete;

  assign w_start_ok = bus.i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_counting = (r_state == MEASURE) || (r_state == DRAIN);
  // Uses the registered counters, so a final delivery still sitting in the
  // popcount stage cannot end the drain early by more than the pipeline.
  assign w_complete = (r_delivered == r_injected) && (&bus.i_src_empty);

  // Per-port in-window qualification; the unsigned difference tolerates wrap.
  always_comb begin
    w_tx_hit = '0;
    w_rx_hit = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_tx_hit[p] = bus.i_tx_valid[p] && w_counting &&
                    ((bus.i_tx_ts[p] - r_win_start) < WINDOW_LEN);
      w_rx_hit[p] = bus.i_rx_valid[p] && w_counting &&
                    ((bus.i_rx_ts[p] - r_win_start) < WINDOW_LEN);
    end
  end

  nemu_popcount #(.WIDTH(PORTS)) u_tx_popcount (.i_bits(w_tx_hit), .o_count(w_tx_cnt));
  nemu_popcount #(.WIDTH(PORTS)) u_rx_popcount (.i_bits(w_rx_hit), .o_count(w_rx_cnt));

  // Phase state register.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-phase decision; completion takes priority over the drain timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.i_start) w_next_state = WARMUP;
        else             w_next_state = r_state;
      end
      WARMUP: begin
        if (r_phase_cnt == WARMUP_LAST) w_next_state = MEASURE;
        else                            w_next_state = WARMUP;
      end
      MEASURE: begin
        if (r_phase_cnt == MEASURE_LAST) w_next_state = DRAIN;
        else                             w_next_state = MEASURE;
      end
      DRAIN: begin
        if (w_complete || (r_phase_cnt == DRAIN_LAST)) w_next_state = DONE;
        else                                           w_next_state = DRAIN;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming phase so the registered outputs track it.
  always_comb begin
    w_src_enable_next = '0;
    w_done_next       = 1'b0;
    case (w_next_state)
      WARMUP, MEASURE: w_src_enable_next = {PORTS{1'b1}};
      DONE:            w_done_next       = 1'b1;
      default: begin
        w_src_enable_next = '0;
        w_done_next       = 1'b0;
      end
    endcase
  end

  // Registered outputs, timestamp, phase counter, window base and counters.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src_enable <= '0;
      r_done       <= 1'b0;
      r_timestamp  <= '0;
      r_phase_cnt  <= '0;
      r_win_start  <= '0;
      r_injected   <= '0;
      r_delivered  <= '0;
      r_tx_cnt     <= '0;
      r_rx_cnt     <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_src_enable <= w_src_enable_next;
      r_done       <= w_done_next;
      r_timestamp  <= r_timestamp + 32'd1;

      if (w_next_state != r_state) r_phase_cnt <= '0;
      else                         r_phase_cnt <= r_phase_cnt + 32'd1;

      // Base is the timestamp seen during the first MEASURE cycle.
      if ((r_state == WARMUP) && (w_next_state == MEASURE)) r_win_start <= r_timestamp + 32'd1;
      else                                                  r_win_start <= r_win_start;

      if (w_start_ok) begin
        r_injected  <= '0;
        r_delivered <= '0;
        r_tx_cnt    <= '0;
        r_rx_cnt    <= '0;
        r_timeout   <= 1'b0;
      end else begin
        r_injected  <= nemu_sat_add(r_injected, NEMU_TS_W'(r_tx_cnt));
        r_delivered <= nemu_sat_add(r_delivered, NEMU_TS_W'(r_rx_cnt));
        r_tx_cnt    <= w_tx_cnt;
        r_rx_cnt    <= w_rx_cnt;
        if ((r_state == DRAIN) && (w_next_state == DONE) && !w_complete) r_timeout <= 1'b1;
        else                                                             r_timeout <= r_timeout;
      end
    end
  end

  assign bus.o_timestamp  = r_timestamp;
  assign bus.o_src_enable = r_src_enable;
  assign bus.o_state      = r_state;
  assign bus.o_injected   = r_injected;
  assign bus.o_delivered  = r_delivered;
  assign bus.o_done       = r_done;
  assign bus.o_timeout    = r_timeout;

endmodule

// File: tb/tb_nemu_traffic_controller.sv
// Self-checking bench for nemu_traffic_controller with a run-level
// reference model (elapsed-cycle arithmetic plus event totals).
module tb_nemu_traffic_controller;
  import nemu_pkg::*;

  localparam int P = 4;
  localparam int W = 4;
  localparam int M = 8;
  localparam int D = 16;

  logic i_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  nemu_traffic_controller_if #(.PORTS(P)) bus ();

  nemu_traffic_controller #(
    .PORTS(P), .WARMUP_CYCLES(W), .MEASURE_CYCLES(M), .DRAIN_TIMEOUT(D)
  ) dut (
    .i_clk(i_clk), .reset_n(reset_n), .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [31:0] m_ts, m_win, m_inj, m_del, m_pend_tx, m_pend_rx;
  nemu_phase_t m_phase;
  int          m_elapsed, m_drain;
  logic        m_timeout;

  int   mode = 0;
  logic start_req = 1'b0;
  int   en_cycles, drain_cycles;
  logic [31:0] base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'(a) + longint'(b);
    return (s > longint'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : 32'(s);
  endfunction

  function automatic logic [31:0] window_events(input logic [P-1:0] v,
                                                input logic [P-1:0][31:0] ts);
    logic [31:0] n;
    logic [31:0] d;
    n = 32'd0;
    for (int p = 0; p < P; p++) begin
      d = ts[p] - m_win;
      if (v[p] && (d < 32'(M))) n = n + 32'd1;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_ts = 32'd0; m_win = 32'd0; m_inj = 32'd0; m_del = 32'd0;
    m_pend_tx = 32'd0; m_pend_rx = 32'd0;
    m_phase = IDLE; m_elapsed = 0; m_drain = 0; m_timeout = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using inputs held before it.
  task automatic model_edge();
    logic [31:0] new_tx, new_rx;
    logic complete;
    if (!reset_n) begin
      model_reset();
      return;
    end
    new_tx = 32'd0; new_rx = 32'd0;
    if (m_phase == MEASURE || m_phase == DRAIN) begin
      new_tx = window_events(bus.i_tx_valid, bus.i_tx_ts);
      new_rx = window_events(bus.i_rx_valid, bus.i_rx_ts);
    end
    complete = (m_del == m_inj) && (&bus.i_src_empty);
    m_inj = sat(m_inj, m_pend_tx);
    m_del = sat(m_del, m_pend_rx);
    m_pend_tx = new_tx;
    m_pend_rx = new_rx;
    case (m_phase)
      IDLE, DONE: if (bus.i_start) begin
        m_phase = WARMUP; m_elapsed = 0;
        m_inj = 32'd0; m_del = 32'd0; m_pend_tx = 32'd0; m_pend_rx = 32'd0;
        m_timeout = 1'b0;
      end
      WARMUP: begin
        m_elapsed++;
        if (m_elapsed == W) begin m_phase = MEASURE; m_win = m_ts + 32'd1; end
      end
      MEASURE: begin
        m_elapsed++;
        if (m_elapsed == W + M) begin m_phase = DRAIN; m_drain = 0; end
      end
      DRAIN: begin
        m_drain++;
        if (complete) m_phase = DONE;
        else if (m_drain == D) begin m_phase = DONE; m_timeout = 1'b1; end
      end
      default: m_phase = IDLE;
    endcase
    m_ts = m_ts + 32'd1;
  endtask

  task automatic check_outputs();
    chk("timestamp", bus.o_timestamp, m_ts);
    chk("state", 32'(bus.o_state), 32'(m_phase));
    chk("src_enable", 32'(bus.o_src_enable),
        (m_phase == WARMUP || m_phase == MEASURE) ? 32'hF : 32'h0);
    chk("injected", bus.o_injected, m_inj);
    chk("delivered", bus.o_delivered, m_del);
    chk("done", 32'(bus.o_done), 32'(m_phase == DONE));
    chk("timeout", 32'(bus.o_timeout), 32'(m_timeout));
  endtask

  task automatic drive_cycle();
    logic [31:0] wrap_ts [P];
    wrap_ts = '{32'h0000_0002, 32'h0000_0010, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    bus.i_start = start_req;
    bus.i_tx_valid = '0;
    bus.i_rx_valid = '0;
    bus.i_src_empty = '1;
    for (int p = 0; p < P; p++) begin
      bus.i_tx_ts[p] = 32'd0;
      bus.i_rx_ts[p] = 32'd0;
    end
    case (mode)
      1, 2: if (m_phase == MEASURE) begin
        bus.i_tx_valid[0] = 1'b1; bus.i_tx_ts[0] = m_ts;
        if (!(mode == 2 && m_elapsed == W)) begin
          bus.i_rx_valid[0] = 1'b1; bus.i_rx_ts[0] = m_ts;
        end
      end
      4: for (int p = 0; p < P; p++) begin
        bus.i_tx_valid[p] = 1'b1; bus.i_tx_ts[p] = m_win + 32'(p);
      end
      5: for (int p = 0; p < P; p++) begin
        bus.i_tx_valid[p] = 1'b1; bus.i_tx_ts[p] = wrap_ts[p];
      end
      7: for (int p = 0; p < P; p++) begin
        bus.i_tx_valid[p] = 1'b1; bus.i_tx_ts[p] = m_win + 32'(M) + 32'(p);
      end
      6: begin
        if (m_phase != DRAIN || $urandom_range(0, 3) == 0)
          bus.i_tx_valid = P'($urandom_range(0, 15));
        bus.i_rx_valid = P'($urandom_range(0, 15));
        for (int p = 0; p < P; p++) begin
          bus.i_tx_ts[p] = ($urandom_range(0, 3) == 0) ? $urandom : m_win + $urandom_range(0, M - 1);
          bus.i_rx_ts[p] = ($urandom_range(0, 3) == 0) ? $urandom : m_win + $urandom_range(0, M - 1);
        end
        if ($urandom_range(0, 3) == 0) bus.i_src_empty = P'($urandom_range(0, 15));
        if (m_phase inside {WARMUP, MEASURE, DRAIN} && $urandom_range(0, 7) == 0)
          bus.i_start = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    drive_cycle();
    @(posedge i_clk);
    model_edge();
    #1;
    check_outputs();
    if (bus.o_src_enable == 4'hF) en_cycles++;
    if (bus.o_state == DRAIN) drain_cycles++;
  endtask

  task automatic tick_until_phase(input nemu_phase_t ph, input int budget);
    for (int i = 0; i < budget && m_phase != ph; i++) tick();
    chk("reach_phase", 32'(bus.o_state), 32'(ph));
  endtask

  task automatic do_run(input int md, input int budget);
    en_cycles = 0; drain_cycles = 0;
    mode = md; start_req = 1'b1;
    tick();
    start_req = 1'b0;
    for (int i = 0; i < budget && m_phase != DONE; i++) tick();
    chk("run_done", 32'(bus.o_done), 32'd1);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_tx_valid = '0; bus.i_rx_valid = '0;
    bus.i_tx_ts = '0; bus.i_rx_ts = '0; bus.i_src_empty = '1;
    model_reset();
    #3;
    check_outputs();
    #9 reset_n = 1'b1;

    // idle: i_start low for 20 cycles
    for (int i = 0; i < 20; i++) tick();
    chk("idle_ts", bus.o_timestamp, 32'd20);
    chk("idle_state", 32'(bus.o_state), 32'(IDLE));

    // nominal run
    do_run(1, 60);
    chk("nom_en_cycles", 32'(en_cycles), 32'd12);
    chk("nom_inj", bus.o_injected, 32'd8);
    chk("nom_del", bus.o_delivered, 32'd8);
    chk("nom_timeout", 32'(bus.o_timeout), 32'd0);

    // lost packet: drain runs to timeout
    do_run(2, 60);
    chk("lost_drain_cycles", 32'(drain_cycles), 32'(D));
    chk("lost_inj", bus.o_injected, 32'd8);
    chk("lost_del", bus.o_delivered, 32'd7);
    chk("lost_timeout", 32'(bus.o_timeout), 32'd1);

    // burst: four in-window events in one cycle, then four out-of-window
    mode = 0; start_req = 1'b1; tick(); start_req = 1'b0;
    tick_until_phase(MEASURE, 20);
    base = bus.o_injected;
    mode = 4; tick(); mode = 0; tick();
    chk("burst_plus4", bus.o_injected, base + 32'd4);
    mode = 7; tick(); mode = 0; tick(); tick();
    chk("burst_out_of_window", bus.o_injected, base + 32'd4);
    for (int i = 0; i < 60 && m_phase != DONE; i++) tick();
    chk("burst_done", 32'(bus.o_done), 32'd1);

    // timestamp wrap: window base near the top of the range
    start_req = 1'b1; tick(); start_req = 1'b0;
    tick_until_phase(MEASURE, 20);
    force dut.r_win_start = 32'hFFFF_FFFC;
    m_win = 32'hFFFF_FFFC;
    base = bus.o_injected;
    mode = 5; tick(); mode = 0; tick();
    chk("wrap_in_window", bus.o_injected, base + 32'd2);
    for (int i = 0; i < 60 && m_phase != DONE; i++) tick();
    chk("wrap_done", 32'(bus.o_done), 32'd1);
    release dut.r_win_start;

    // randomized runs
    for (int r = 0; r < 4; r++) do_run(6, 80);

    // reset during MEASURE
    mode = 1; start_req = 1'b1; tick(); start_req = 1'b0;
    tick_until_phase(MEASURE, 20);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midreset_state", 32'(bus.o_state), 32'(IDLE));
    chk("midreset_enable", 32'(bus.o_src_enable), 32'd0);
    tick();
    reset_n = 1'b1;
    do_run(1, 60);
    chk("rerun_inj", bus.o_injected, 32'd8);
    chk("rerun_del", bus.o_delivered, 32'd8);
    chk("rerun_timeout", 32'(bus.o_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nemu_traffic_controller.md
# nemu_traffic_controller

Run-phase sequencer for the NEMU traffic generators. It owns the global timestamp and gates every per-port packet source through four phases: warm-up, measurement, drain and done. It also counts the measurement-window packets injected into and delivered by the network. It sits at the top of the emulator beside the network and is the only block that enables or stops packet generation.

## Interface
Parameters:
- PORTS, `PORTS: number of network ports / packet sources.
- WARMUP_CYCLES, 600: cycles in WARMUP before measurement starts.
- MEASURE_CYCLES, 10000: length of the measurement window in cycles.
- DRAIN_TIMEOUT, 20000: maximum cycles spent in DRAIN.

Ports:
- i_clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- i_start, in, 1: start a run; sampled only in IDLE or DONE.
- i_tx_valid, in, PORTS: packet accepted by the network at each source port.
- i_tx_ts, in, PORTS×32: data/timestamp field of each injected packet.
- i_rx_valid, in, PORTS: packet delivered at each network output.
- i_rx_ts, in, PORTS×32: data/timestamp field of each delivered packet.
- i_src_empty, in, PORTS: packet-source FIFO empty flags.
- o_timestamp, out, 32: free-running global time.
- o_src_enable, out, PORTS: per-source generation enable.
- o_state, out, 3: current phase, encoded as nemu_phase_t.
- o_injected, out, 32: count of measurement-window packets injected.
- o_delivered, out, 32: count of measurement-window packets delivered.
- o_done, out, 1: run complete.
- o_timeout, out, 1: drain ended by timeout, not by completion.

## Operation
- Phases are IDLE, WARMUP, MEASURE, DRAIN and DONE. Reset puts the block in IDLE.
- IDLE→WARMUP on i_start. This clears o_injected, o_delivered, o_timeout and the phase counter.
- WARMUP→MEASURE when the phase counter reaches WARMUP_CYCLES-1. On entering MEASURE, the block latches win_start = o_timestamp.
- MEASURE→DRAIN when the phase counter reaches MEASURE_CYCLES-1.
- DRAIN→DONE under either of two conditions:
  - Completion: o_delivered == o_injected and all i_src_empty bits are 1.
  - Timeout: the phase counter reaches DRAIN_TIMEOUT-1. This sets o_timeout. If both conditions hold in the same cycle, completion wins and o_timeout stays 0.
- DONE→WARMUP on i_start, with the same clearing as IDLE. i_start is ignored in all other states.
- o_src_enable is all-ones in WARMUP and MEASURE and zero elsewhere. Sources keep emptying their FIFOs while disabled.
- A packet is in the window when (ts - win_start) mod 2^32 < MEASURE_CYCLES. This unsigned-difference test tolerates timestamp wrap.
- Injected packets are counted in MEASURE and DRAIN when i_tx_valid is set and i_tx_ts is in the window. Delivered packets are counted the same way using i_rx_valid and i_rx_ts.
- Each cycle, up to PORTS events per direction are added to the counts via popcount. Counters saturate at 2^32-1.
- o_timestamp increments every cycle in every state and wraps modulo 2^32.

## Timing
- Reset values: o_timestamp=0, o_src_enable=0, o_state=IDLE, o_injected=0, o_delivered=0, o_done=0, o_timeout=0. Reset is asynchronous and may abort any phase.
- All outputs are registered.
- State and o_src_enable change on the clock edge after the triggering condition. A run starting with i_start high at edge N shows o_src_enable=1 from edge N+1.
- WARMUP lasts exactly WARMUP_CYCLES cycles and MEASURE lasts exactly MEASURE_CYCLES cycles.
- Counter latency: a valid event at edge N is reflected in o_injected/o_delivered after edge N+1. Popcount is registered, then accumulated.
- The completion check uses the registered counters, so DONE follows the final delivery by 2 cycles.
- o_done is high for exactly as long as the state is DONE.

## Structure
- nemu_pkg holds the nemu_phase_t enum (IDLE=0, WARMUP=1, MEASURE=2, DRAIN=3, DONE=4) and the timestamp width constant (32).
- One sub-module, nemu_popcount, parameterised by width, returns the count of set bits. It is instantiated twice, once for tx and once for rx.

## Test plan
All scenarios use PORTS=4, WARMUP=4, MEASURE=8, DRAIN_TIMEOUT=16.
- Reset then idle: hold i_start=0 for 20 cycles → state stays IDLE, enable=0, o_timestamp=20.
- Nominal run: pulse i_start at t=2, inject and deliver one window packet per cycle on port 0 during MEASURE → enable high for exactly 12 cycles, o_injected=o_delivered=8, DONE with o_timeout=0.
- Burst popcount: in one cycle assert all 4 i_tx_valid with in-window timestamps → o_injected increases by 4 two edges later. Out-of-window timestamps are not counted.
- Lost packet: inject 8 and deliver 7 → DRAIN lasts 16 cycles, then DONE with o_timeout=1.
- Timestamp wrap: force win_start=0xFFFFFFFC and inject ts=0x00000002 → counted as in window.
- Reset mid-run: deassert reset_n during MEASURE → all outputs return to reset values immediately; a subsequent i_start runs a clean run with counters starting from 0.
